// File: rtl/dram_wr_pkg.sv
// Shared types and width helpers for the DRAM write address generator.
package dram_wr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        XFER = 2'd2,
        GAP  = 2'd3
    } state_t;

    function automatic int ch_w(input int ch_per_buf);
        return $clog2(ch_per_buf);
    endfunction

    function automatic int off_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int addr_w(input int n_buf, input int ch_per_buf, input int depth);
        return $clog2(n_buf) + ch_w(ch_per_buf) + off_w(depth);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set mask bit at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    always_comb begin
        int idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_valid && mask[IDX_W'(idx)]) begin
                grant_valid           = 1'b1;
                grant_idx             = IDX_W'(idx);
                grant[IDX_W'(idx)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_wr_addr_gen_rr.sv
// Round-robin drain of N_BUF reorder buffers into DRAM, one frame per grant, per-buffer ring offsets.
// Define DRAM_WR_STATS_EN to add saturating frame/stall counters.
module dram_wr_addr_gen_rr
    import dram_wr_pkg::*;
#(
    parameter int N_BUF      = 8,
    parameter int CH_PER_BUF = 125,
    parameter int DATA_W     = 256,
    parameter int DEPTH      = 16384,
    parameter int GAP_CYC    = 4,
    localparam int SEL_W     = $clog2(N_BUF),
    localparam int CH_W      = ch_w(CH_PER_BUF),
    localparam int OFF_W     = off_w(DEPTH),
    localparam int ADDR_W    = addr_w(N_BUF, CH_PER_BUF, DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_BUF-1:0]  buf_ready,
    input  logic [DATA_W-1:0] buf_rd_data,
    output logic [N_BUF-1:0]  buf_rd_req,
    output logic [SEL_W-1:0]  buf_sel,
    input  logic              dram_waitrequest,
    output logic              dram_write,
    output logic              dram_burstbegin,
    output logic [4:0]        dram_burstcount,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_wdata,
    output logic [N_BUF-1:0]  wrap_pulse,
    output logic              busy
`ifdef DRAM_WR_STATS_EN
    ,
    output logic [31:0]       stat_frames,
    output logic [31:0]       stat_stall
`endif
);

    localparam int CNT_W = CH_W + 1;
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    state_t state_reg, state_next;

    logic [SEL_W-1:0]             sel_reg;
    logic [SEL_W-1:0]             ptr_reg;
    logic [N_BUF-1:0]             sel_onehot_reg;
    logic [CH_W-1:0]              chan_reg;
    logic [CNT_W-1:0]             rd_cnt_reg;
    logic [GAP_W-1:0]             gap_cnt_reg;
    logic [N_BUF-1:0][OFF_W-1:0]  offset_reg;
    logic [N_BUF-1:0]             wrap_pulse_reg;

    logic [DATA_W-1:0]            fifo_mem [2];
    logic                         fifo_wr_ptr_reg;
    logic                         fifo_rd_ptr_reg;
    logic [1:0]                   fifo_cnt_reg;
    logic                         inflight_reg;

    logic [N_BUF-1:0]             grant_onehot;
    logic [SEL_W-1:0]             grant_idx;
    logic                         grant_valid;

    logic                         accept;
    logic                         frame_done;
    logic                         issue;
    logic [2:0]                   pending;

    rr_arbiter #(
        .N (N_BUF)
    ) u_arb (
        .mask        (buf_ready),
        .ptr         (ptr_reg),
        .grant       (grant_onehot),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign dram_write = (fifo_cnt_reg != 2'd0);
    assign accept     = dram_write && !dram_waitrequest;
    assign frame_done = accept && (chan_reg == CH_W'(CH_PER_BUF - 1));

    // Count this cycle's pop so a steady stream keeps one read per cycle without bubbles.
    assign pending    = 3'(fifo_cnt_reg) + 3'(inflight_reg) - 3'(accept);
    assign issue      = (state_reg == XFER) && (rd_cnt_reg < CNT_W'(CH_PER_BUF)) && (pending < 3'd2);

    assign buf_rd_req      = issue ? sel_onehot_reg : '0;
    assign buf_sel         = sel_reg;
    assign dram_burstbegin = dram_write;
    assign dram_burstcount = 5'd1;
    assign dram_addr       = {sel_reg, chan_reg, offset_reg[sel_reg]};
    assign dram_wdata      = dram_write ? fifo_mem[fifo_rd_ptr_reg] : '0;
    assign wrap_pulse      = wrap_pulse_reg;
    assign busy            = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (|buf_ready) state_next = ARB;
            ARB:  state_next = grant_valid ? XFER : IDLE;
            XFER: if (frame_done) state_next = GAP;
            GAP:  if (gap_cnt_reg == GAP_W'(GAP_CYC - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_reg        <= '0;
            ptr_reg        <= '0;
            sel_onehot_reg <= '0;
            chan_reg       <= '0;
            rd_cnt_reg     <= '0;
            gap_cnt_reg    <= '0;
        end else begin
            if (state_reg == ARB) begin
                chan_reg   <= '0;
                rd_cnt_reg <= '0;
                if (grant_valid) begin
                    sel_reg        <= grant_idx;
                    sel_onehot_reg <= grant_onehot;
                    ptr_reg        <= (grant_idx == SEL_W'(N_BUF - 1)) ? '0 : grant_idx + 1'b1;
                end
            end else begin
                if (issue) begin
                    rd_cnt_reg <= rd_cnt_reg + 1'b1;
                end
                if (frame_done) begin
                    chan_reg <= '0;
                end else if (accept) begin
                    chan_reg <= chan_reg + 1'b1;
                end
            end
            gap_cnt_reg <= (state_reg == GAP) ? gap_cnt_reg + 1'b1 : '0;
        end
    end

    // Skid FIFO: pushes arrive one cycle after each read pulse, pops on DRAM accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_wr_ptr_reg <= 1'b0;
            fifo_rd_ptr_reg <= 1'b0;
            fifo_cnt_reg    <= 2'd0;
            inflight_reg    <= 1'b0;
        end else begin
            inflight_reg <= issue;
            if (inflight_reg) begin
                fifo_wr_ptr_reg <= ~fifo_wr_ptr_reg;
            end
            if (accept) begin
                fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
            end
            fifo_cnt_reg <= fifo_cnt_reg + 2'(inflight_reg) - 2'(accept);
        end
    end

    always_ff @(posedge clk) begin
        if (inflight_reg) begin
            fifo_mem[fifo_wr_ptr_reg] <= buf_rd_data;
        end
    end

    generate
        for (genvar gi = 0; gi < N_BUF; gi++) begin : g_ring
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    offset_reg[gi]     <= '0;
                    wrap_pulse_reg[gi] <= 1'b0;
                end else begin
                    wrap_pulse_reg[gi] <= 1'b0;
                    if (frame_done && (sel_reg == SEL_W'(gi))) begin
                        offset_reg[gi] <= offset_reg[gi] + 1'b1;
                        if (offset_reg[gi] == OFF_W'(DEPTH - 1)) begin
                            wrap_pulse_reg[gi] <= 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

`ifdef DRAM_WR_STATS_EN
    logic [31:0] stat_frames_reg;
    logic [31:0] stat_stall_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_frames_reg <= '0;
            stat_stall_reg  <= '0;
        end else begin
            if (frame_done && (stat_frames_reg != '1)) begin
                stat_frames_reg <= stat_frames_reg + 1'b1;
            end
            if (dram_write && dram_waitrequest && (stat_stall_reg != '1)) begin
                stat_stall_reg <= stat_stall_reg + 1'b1;
            end
        end
    end

    assign stat_frames = stat_frames_reg;
    assign stat_stall  = stat_stall_reg;
`endif

endmodule

// File: tb/tb_dram_wr_addr_gen_rr.sv
// Directed, table-driven bench for dram_wr_addr_gen_rr with a 1-cycle-latency buffer model.
module tb_dram_wr_addr_gen_rr;

    localparam int N_BUF   = 8;
    localparam int CH      = 125;
    localparam int DATA_W  = 256;
    localparam int DEPTH   = 4;
    localparam int GAP_CYC = 4;
    localparam int SEL_W   = $clog2(N_BUF);
    localparam int CH_W    = $clog2(CH);
    localparam int OFF_W   = $clog2(DEPTH);
    localparam int ADDR_W  = SEL_W + CH_W + OFF_W;
    localparam int NVEC    = 17;

    // wmode: 0 no stall, 1 random 50%, 2 stall loop cycles 10..39, 3 stall loop cycles 10..19
    typedef struct {
        logic [N_BUF-1:0] ready;
        int               wmode;
        int               exp_sel;
        int               exp_off;
        bit               exp_wrap;
        bit               hold;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N_BUF-1:0]  buf_ready = '0;
    logic [DATA_W-1:0] buf_rd_data;
    logic [N_BUF-1:0]  buf_rd_req;
    logic [SEL_W-1:0]  buf_sel;
    logic              dram_waitrequest = 1'b0;
    logic              dram_write;
    logic              dram_burstbegin;
    logic [4:0]        dram_burstcount;
    logic [ADDR_W-1:0] dram_addr;
    logic [DATA_W-1:0] dram_wdata;
    logic [N_BUF-1:0]  wrap_pulse;
    logic              busy;
`ifdef DRAM_WR_STATS_EN
    logic [31:0]       stat_frames;
    logic [31:0]       stat_stall;
`endif

    int compared   = 0;
    int mismatched = 0;
    int rd_idx;
    vec_t vecs [NVEC];
    vec_t post [3];

    dram_wr_addr_gen_rr #(
        .N_BUF      (N_BUF),
        .CH_PER_BUF (CH),
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .GAP_CYC    (GAP_CYC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .buf_ready        (buf_ready),
        .buf_rd_data      (buf_rd_data),
        .buf_rd_req       (buf_rd_req),
        .buf_sel          (buf_sel),
        .dram_waitrequest (dram_waitrequest),
        .dram_write       (dram_write),
        .dram_burstbegin  (dram_burstbegin),
        .dram_burstcount  (dram_burstcount),
        .dram_addr        (dram_addr),
        .dram_wdata       (dram_wdata),
        .wrap_pulse       (wrap_pulse),
        .busy             (busy)
`ifdef DRAM_WR_STATS_EN
        ,
        .stat_frames      (stat_frames),
        .stat_stall       (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mk_word(input int b, input int idx);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int k = 0; k < DATA_W / 32; k++) begin
            w[k*32 +: 32] = 32'h5A00_0000 + 32'(b * 1000 + idx * 7 + k * 13);
        end
        return w;
    endfunction

    function automatic int req_idx(input logic [N_BUF-1:0] req);
        int r;
        r = 0;
        for (int i = 0; i < N_BUF; i++) begin
            if (req[i]) r = i;
        end
        return r;
    endfunction

    function automatic logic [N_BUF-1:0] onehot(input int i);
        return N_BUF'(1) << i;
    endfunction

    // Reorder-buffer model: word n of the granted buffer appears one cycle after its read pulse.
    always @(posedge clk) begin
        if (!rst_n) begin
            rd_idx <= 0;
        end else if (|buf_rd_req) begin
            buf_rd_data <= mk_word(req_idx(buf_rd_req), rd_idx);
            rd_idx      <= (rd_idx == CH - 1) ? 0 : rd_idx + 1;
        end else begin
            buf_rd_data <= {8{$urandom}};
        end
    end

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_write"}, dram_write, 0);
        check({tag, "_burstbegin"}, dram_burstbegin, 0);
        check({tag, "_rd_req"}, buf_rd_req, 0);
        check({tag, "_sel"}, buf_sel, 0);
        check({tag, "_addr"}, dram_addr, 0);
        check({tag, "_wdata"}, dram_wdata, 0);
        check({tag, "_wrap"}, wrap_pulse, 0);
`ifdef DRAM_WR_STATS_EN
        check({tag, "_stat_frames"}, stat_frames, 0);
        check({tag, "_stat_stall"}, stat_stall, 0);
`endif
    endtask

    task automatic run_frame(input vec_t v);
        int arb_cyc, first_cyc, last_cyc, acc, rds, gap_len;
        bit busy_prev, prev_stall;
        logic [ADDR_W-1:0] prev_addr, exp_addr;
        logic [DATA_W-1:0] prev_wdata;
        arb_cyc = -1; first_cyc = -1; last_cyc = -1;
        acc = 0; rds = 0; prev_stall = 1'b0;
        prev_addr = '0; prev_wdata = '0;
        busy_prev = busy;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc == 0) buf_ready = v.ready;
            case (v.wmode)
                0: dram_waitrequest = 1'b0;
                1: dram_waitrequest = 1'($urandom_range(0, 1));
                2: dram_waitrequest = (cyc >= 10 && cyc < 40);
                default: dram_waitrequest = (cyc >= 10 && cyc < 20);
            endcase
            #1;
            if (busy && !busy_prev && arb_cyc < 0) arb_cyc = cyc;
            busy_prev = busy;
            if (prev_stall) begin
                check("stall_write_held", dram_write, 1);
                check("stall_addr_held", dram_addr, prev_addr);
                check("stall_wdata_held", dram_wdata, prev_wdata);
            end
            if (|buf_rd_req) begin
                rds++;
                check("rd_req_onehot", buf_rd_req, onehot(int'(buf_sel)));
            end
            if (dram_write) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    check("first_write_latency", cyc - arb_cyc, 3);
                    check("grant", buf_sel, v.exp_sel);
                    if (!v.hold) buf_ready = '0;
                end
                if (!dram_waitrequest) begin
                    exp_addr = {SEL_W'(v.exp_sel), CH_W'(acc), OFF_W'(v.exp_off)};
                    check("addr", dram_addr, exp_addr);
                    check("wdata", dram_wdata, mk_word(v.exp_sel, acc));
                    check("burst", {dram_burstbegin, dram_burstcount}, 6'b1_00001);
                    acc++;
                    last_cyc = cyc;
                end
            end
            check("in_flight_le2", (rds - acc) <= 2, 1);
            prev_stall = dram_write && dram_waitrequest;
            prev_addr  = dram_addr;
            prev_wdata = dram_wdata;
            if (acc == CH) break;
        end
        dram_waitrequest = 1'b0;
        check("frame_words", acc, CH);
        check("frame_reads", rds, CH);
        if (v.wmode == 0) check("no_bubbles", last_cyc - first_cyc, CH - 1);
        gap_len = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            #1;
            if (t == 0) check("wrap_pulse", wrap_pulse, v.exp_wrap ? onehot(v.exp_sel) : '0);
            if (t == 1) check("wrap_pulse_1cyc", wrap_pulse, 0);
            if (!busy) break;
            check("gap_quiet", {dram_write, buf_rd_req}, 0);
            gap_len++;
        end
        check("gap_len", gap_len, GAP_CYC);
        $display("frame ready=%02h sel=%0d off=%0d wmode=%0d words=%0d", v.ready, v.exp_sel, v.exp_off, v.wmode, acc);
    endtask

    initial begin
        int seen;
        vecs = '{
            '{8'h04, 0, 2, 0, 1'b0, 1'b0},
            '{8'h04, 1, 2, 1, 1'b0, 1'b0},
            '{8'hFF, 0, 3, 0, 1'b0, 1'b1},
            '{8'hFF, 0, 4, 0, 1'b0, 1'b1},
            '{8'hFF, 1, 5, 0, 1'b0, 1'b1},
            '{8'hFF, 0, 6, 0, 1'b0, 1'b1},
            '{8'hFF, 0, 7, 0, 1'b0, 1'b1},
            '{8'hFF, 0, 0, 0, 1'b0, 1'b1},
            '{8'hFF, 0, 1, 0, 1'b0, 1'b1},
            '{8'hFF, 0, 2, 2, 1'b0, 1'b1},
            '{8'h20, 0, 5, 1, 1'b0, 1'b0},
            '{8'h20, 1, 5, 2, 1'b0, 1'b0},
            '{8'h20, 2, 5, 3, 1'b1, 1'b0},
            '{8'h20, 0, 5, 0, 1'b0, 1'b0},
            '{8'h81, 0, 7, 1, 1'b0, 1'b0},
            '{8'h81, 1, 0, 1, 1'b0, 1'b0},
            '{8'h81, 0, 7, 2, 1'b0, 1'b0}
        };
        post = '{
            '{8'h08, 3, 3, 0, 1'b0, 1'b0},
            '{8'h08, 0, 3, 1, 1'b0, 1'b0},
            '{8'h08, 0, 3, 2, 1'b0, 1'b0}
        };

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_frame(vecs[i]);
        end

        // Abort a frame with reset while word 60 is on the bus.
        @(negedge clk);
        buf_ready = 8'h08;
        dram_waitrequest = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 400 && seen < 61; cyc++) begin
            @(negedge clk);
            #1;
            if (dram_write) seen++;
        end
        check("abort_word60_chan", dram_addr[OFF_W +: CH_W], 60);
        @(negedge clk);
        rst_n = 1'b0;
        buf_ready = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_outputs("abort");
        $display("abort at word %0d", seen - 1);

        for (int i = 0; i < 3; i++) begin
            run_frame(post[i]);
        end
`ifdef DRAM_WR_STATS_EN
        check("stat_frames", stat_frames, 3);
        check("stat_stall", stat_stall, 10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dram_wr_addr_gen_rr.md
Name: dram_wr_addr_gen_rr

Overview:
- Parametrised successor of the DarkMatter DRAM write address generator.
- Round-robin arbitrates among N_BUF channel-reorder buffers and drains one complete frame (CH_PER_BUF words) from the winner.
- Writes the frame to DRAM over an Avalon-MM master. Each word is addressed {buf, channel, time_offset}.
- Keeps a per-buffer ring offset that wraps at DEPTH. This is the replacement scheme: the oldest sample slot is overwritten.

Parameters:
- N_BUF, 8, number of reorder buffers (>=2)
- CH_PER_BUF, 125, words per frame; word 0 is the timestamp, words 1..CH_PER_BUF-1 are channel data
- DATA_W, 256, DRAM/buffer data width
- DEPTH, 16384, time slots per channel ring (power of 2)
- GAP_CYC, 4, idle cycles after a frame so the buffer can clear ready (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- buf_ready  in  N_BUF  per-buffer frame-ready level
- buf_rd_data  in  DATA_W  muxed read data; valid exactly 1 cycle after a buf_rd_req pulse
- buf_rd_req  out  N_BUF  one-hot read pulse, one word per pulse
- buf_sel  out  $clog2(N_BUF)  currently granted buffer index
- dram_waitrequest  in  1  Avalon stall, active high
- dram_write  out  1  write strobe
- dram_burstbegin  out  1  high with every dram_write (single-beat bursts)
- dram_burstcount  out  5  constant 1
- dram_addr  out  ADDR_W  {buf_sel, chan[CH_W-1:0], offset[OFF_W-1:0]}
- dram_wdata  out  DATA_W  write data
- wrap_pulse  out  N_BUF  1-cycle pulse when that buffer's offset wraps DEPTH-1 to 0
- busy  out  1  high in every state except IDLE

Width rules: CH_W=$clog2(CH_PER_BUF), OFF_W=$clog2(DEPTH), ADDR_W=$clog2(N_BUF)+CH_W+OFF_W.

Behaviour:
- Reset: all outputs 0; all offsets 0; round-robin pointer 0; state IDLE. Reset mid-frame aborts the frame with no further strobes.
- States:
  - IDLE: if buf_ready != 0, go to ARB.
  - ARB (1 cycle): the rr_arbiter grants the first ready index at or above ptr, wrapping. buf_sel is latched and ptr <= grant+1 (mod N_BUF). If the grant is empty (ready dropped), return to IDLE.
  - XFER: moves the frame (see handshake below).
  - GAP: held GAP_CYC cycles, then IDLE.
- XFER handshake:
  - A 2-entry skid FIFO decouples the 1-cycle buffer read latency from dram_waitrequest.
  - buf_rd_req pulses only when (FIFO occupancy + reads in flight) < 2 and fewer than CH_PER_BUF reads have been issued.
  - dram_write is asserted while the FIFO is non-empty.
  - addr/wdata/write stay stable while dram_waitrequest=1. A word is accepted on a cycle with dram_write=1 and dram_waitrequest=0.
  - chan counts 0..CH_PER_BUF-1 on accepted words.
- Frame end: the accept of chan=CH_PER_BUF-1 ends the frame.
  - offset[buf_sel] increments, wrapping to 0 after DEPTH-1; wrap_pulse[buf_sel] fires on the wrap.
  - State goes to GAP.
- Throughput: with dram_waitrequest=0 throughout, the first dram_write is 2 cycles after ARB exit. One word per cycle follows, with no bubbles.
- Boundaries:
  - No read is issued beyond CH_PER_BUF words.
  - The FIFO never overflows under any waitrequest pattern.
  - buf_ready deasserting mid-frame is ignored; the frame completes.
  - Simultaneous ready on all buffers: strict rotation, no starvation.
  - dram_waitrequest held high indefinitely: outputs stay frozen, no protocol violation.

Optional Feature:
- DRAM_WR_STATS_EN defined: adds outputs stat_frames (32b, per-buffer-agnostic count of completed frames) and stat_stall (32b, cycles with dram_write=1 and dram_waitrequest=1). Both saturate at all-ones and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package dram_wr_pkg: state enum (IDLE, ARB, XFER, GAP) and width helper functions (ch_w, off_w, addr_w).
- Sub-module rr_arbiter: combinational grant from mask+ptr, one-hot plus index outputs, parametrised N. The skid FIFO stays inline.

Test Plan:
- buf_ready=8'h04, waitrequest=0 -> 125 consecutive writes, addresses {3'd2,chan 0..124,offset 0}; offset[2]=1 afterwards; first write 2 cycles after ARB.
- buf_ready=8'hFF held, 16 frames -> grant order 0,1,...,7,0,...,7 with a GAP of 4 cycles between frames.
- Random waitrequest at 50% -> every accepted wdata matches the buffer model in order, no duplicate or missing chan, at most 2 words in flight.
- 16384 frames on buffer 5 -> wrap_pulse[5] fires once on the last frame; the next frame uses offset 0.
- rst_n low at word 60 of a frame -> next cycle all outputs 0, offsets 0, state IDLE; the next frame restarts at chan 0.
- DRAM_WR_STATS_EN: 3 frames with 10 forced stall cycles -> stat_frames=3, stat_stall=10.
